// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl: boot sequencer for the instruction memory.
//
// Packs UART bytes (little-endian) into 32-bit words and writes them into instruction
// memory through one write port. Once the terminator word has been written, it hands
// control to the core. If memory fills up without a terminator, it stops in an error state.
//
// Ports:
//   clk, rstn         clock, synchronous active-low reset
//   start             pulse: begin (re)load; ignored while loading
//   rx_valid, rx_data received byte strobe and data
//   imem_we/addr/wdata  instruction-memory write port (registered, one-cycle we)
//   mode              0=STALL, 1=LOAD, 2=EXEC, 3=ERR (current state)
//   cpu_rstn          active-low core reset, high only in EXEC
//   done, err         image loaded / overflow levels
//   word_count        words written in the current load
module imem_boot_ctrl #(
    parameter int unsigned INST_SIZE = 10,
    parameter logic [31:0] TERM_WORD = 32'h0000003F
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    output logic                 imem_we,
    output logic [INST_SIZE-1:0] imem_addr,
    output logic [31:0]          imem_wdata,
    output logic [1:0]           mode,
    output logic                 cpu_rstn,
    output logic                 done,
    output logic                 err,
    output logic [INST_SIZE:0]   word_count
);

    typedef enum logic [1:0] {
        StStall = 2'd0,
        StLoad  = 2'd1,
        StExec  = 2'd2,
        StErr   = 2'd3
    } state_e;

    localparam logic [INST_SIZE-1:0] LastAddr = {INST_SIZE{1'b1}};

    state_e                 state_q, state_d;
    logic [1:0]             byte_cnt_q, byte_cnt_d;
    logic [23:0]            asm_q, asm_d;
    logic                   imem_we_q, imem_we_d;
    logic [INST_SIZE-1:0]   imem_addr_q, imem_addr_d;
    logic [31:0]            imem_wdata_q, imem_wdata_d;
    logic                   cpu_rstn_q, cpu_rstn_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [INST_SIZE:0]     word_count_q, word_count_d;

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        asm_d        = asm_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_rstn_d   = cpu_rstn_q;
        done_d       = done_q;
        err_d        = err_q;
        word_count_d = word_count_q;

        unique case (state_q)
            StLoad: begin
                if (rx_valid) begin
                    // Shift right so the first byte ends up in [7:0] after four bytes.
                    asm_d      = {rx_data, asm_q[23:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        imem_we_d    = 1'b1;
                        imem_wdata_d = {rx_data, asm_q};
                    end
                end
                // The edge that ends a write cycle commits the word.
                if (imem_we_q) begin
                    word_count_d = word_count_q + 1'b1;
                    if (imem_addr_q != LastAddr) begin
                        imem_addr_d = imem_addr_q + 1'b1;
                    end
                    if (imem_wdata_q == TERM_WORD) begin
                        state_d    = StExec;
                        done_d     = 1'b1;
                        cpu_rstn_d = 1'b1;
                    end else if (imem_addr_q == LastAddr) begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end
                end
            end
            default: begin
                // STALL, EXEC and ERR: bytes are dropped, only start matters.
                if (start) begin
                    state_d      = StLoad;
                    byte_cnt_d   = 2'd0;
                    imem_addr_d  = '0;
                    word_count_d = '0;
                    cpu_rstn_d   = 1'b0;
                    done_d       = 1'b0;
                    err_d        = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= StStall;
            byte_cnt_q   <= 2'd0;
            asm_q        <= 24'd0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'd0;
            cpu_rstn_q   <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            asm_q        <= asm_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_rstn_q   <= cpu_rstn_d;
            done_q       <= done_d;
            err_q        <= err_d;
            word_count_q <= word_count_d;
        end
    end

    assign mode       = state_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_rstn   = cpu_rstn_q;
    assign done       = done_q;
    assign err        = err_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl: a default-size instance (l_*) and a 4-word
// instance (s_*) share one stimulus; each is checked where it matters.
module tb_imem_boot_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;

    logic        l_we, l_cpu_rstn, l_done, l_err;
    logic [9:0]  l_addr;
    logic [31:0] l_wdata;
    logic [1:0]  l_mode;
    logic [10:0] l_wc;

    logic        s_we, s_cpu_rstn, s_done, s_err;
    logic [1:0]  s_addr;
    logic [31:0] s_wdata;
    logic [1:0]  s_mode;
    logic [2:0]  s_wc;

    imem_boot_ctrl dut_l (
        .clk(clk), .rstn(rstn), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .imem_we(l_we), .imem_addr(l_addr), .imem_wdata(l_wdata), .mode(l_mode),
        .cpu_rstn(l_cpu_rstn), .done(l_done), .err(l_err), .word_count(l_wc)
    );

    imem_boot_ctrl #(.INST_SIZE(2)) dut_s (
        .clk(clk), .rstn(rstn), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata), .mode(s_mode),
        .cpu_rstn(s_cpu_rstn), .done(s_done), .err(s_err), .word_count(s_wc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int wr_l = 0;
    int wr_s = 0;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    // Write log, sampled mid-cycle.
    always @(negedge clk) begin
        if (l_we) begin
            log_addr.push_back(32'(l_addr));
            log_data.push_back(l_wdata);
            wr_l++;
        end
        if (s_we) wr_s++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Called at a negedge; returns at the negedge after the byte's accepting edge.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("rst_mode", 32'(l_mode), 0);
        check("rst_cpu_rstn", 32'(l_cpu_rstn), 0);
        check("rst_done", 32'(l_done), 0);
        check("rst_err", 32'(l_err), 0);
        check("rst_we", 32'(l_we), 0);
        check("rst_addr", 32'(l_addr), 0);
        check("rst_wdata", l_wdata, 0);
        check("rst_wc", 32'(l_wc), 0);
        rstn = 1'b1;
        @(negedge clk);

        // Byte in STALL and byte coincident with start must both be dropped.
        send_byte(8'hAA);
        check("stall_mode", 32'(l_mode), 0);
        start = 1'b1; rx_valid = 1'b1; rx_data = 8'hBB;
        @(negedge clk);
        start = 1'b0; rx_valid = 1'b0;
        check("start_mode", 32'(l_mode), 1);

        // Two-word image, back-to-back bytes.
        send_word(32'h00000013);
        send_word(32'h0000003F);
        check("t1_we", 32'(l_we), 1);
        check("t1_addr", 32'(l_addr), 1);
        check("t1_wdata", l_wdata, 32'h3F);
        check("t1_done_early", 32'(l_done), 0);
        @(negedge clk);
        check("t1_mode", 32'(l_mode), 2);
        check("t1_done", 32'(l_done), 1);
        check("t1_cpu_rstn", 32'(l_cpu_rstn), 1);
        check("t1_wc", 32'(l_wc), 2);
        check("t1_we_low", 32'(l_we), 0);
        #1;
        check("t1_nwr", 32'(wr_l), 2);
        check("t1_a0", log_addr[0], 0);
        check("t1_d0", log_data[0], 32'h13);
        check("t1_a1", log_addr[1], 1);
        check("t1_d1", log_data[1], 32'h3F);

        // Reload from EXEC.
        @(negedge clk);
        pulse_start();
        check("t4_mode", 32'(l_mode), 1);
        check("t4_cpu_rstn", 32'(l_cpu_rstn), 0);
        check("t4_done", 32'(l_done), 0);
        send_word(32'h0000003F);
        @(negedge clk);
        check("t4_mode_exec", 32'(l_mode), 2);
        check("t4_wc", 32'(l_wc), 1);
        #1;
        check("t4_nwr", 32'(wr_l), 3);
        check("t4_a", log_addr[2], 0);
        check("t4_d", log_data[2], 32'h3F);

        // Widely spaced bytes.
        @(negedge clk);
        pulse_start();
        send_byte(8'h78); repeat (433) @(negedge clk);
        send_byte(8'h56); repeat (433) @(negedge clk);
        send_byte(8'h34); repeat (433) @(negedge clk);
        check("t2_nwr_before", 32'(wr_l), 3);
        send_byte(8'h12);
        check("t2_we", 32'(l_we), 1);
        check("t2_addr", 32'(l_addr), 0);
        check("t2_wdata", l_wdata, 32'h12345678);
        @(negedge clk);
        check("t2_we_low", 32'(l_we), 0);
        check("t2_mode", 32'(l_mode), 1);
        #1;
        check("t2_nwr", 32'(wr_l), 4);
        @(negedge clk);
        send_word(32'h0000003F);
        @(negedge clk);
        check("t2_mode_exec", 32'(l_mode), 2);
        check("t2_wc", 32'(l_wc), 2);

        // Reset in the middle of a word.
        pulse_start();
        send_byte(8'hAA);
        send_byte(8'hBB);
        rstn = 1'b0;
        @(negedge clk);
        check("t5_mode", 32'(l_mode), 0);
        check("t5_wc", 32'(l_wc), 0);
        check("t5_cpu_rstn", 32'(l_cpu_rstn), 0);
        rstn = 1'b1;
        @(negedge clk);
        pulse_start();
        send_word(32'h0000003F);
        check("t5_we", 32'(l_we), 1);
        check("t5_addr", 32'(l_addr), 0);
        check("t5_wdata", l_wdata, 32'h3F);
        @(negedge clk);
        check("t5_mode_exec", 32'(l_mode), 2);

        // Overflow on the 4-word instance.
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        wr_s = 0;
        pulse_start();
        for (int w = 1; w <= 4; w++) send_word(32'(w));
        check("t3_we", 32'(s_we), 1);
        check("t3_addr", 32'(s_addr), 3);
        check("t3_wdata", s_wdata, 4);
        @(negedge clk);
        check("t3_mode", 32'(s_mode), 3);
        check("t3_err", 32'(s_err), 1);
        check("t3_cpu_rstn", 32'(s_cpu_rstn), 0);
        check("t3_wc", 32'(s_wc), 4);
        check("t3_addr_hold", 32'(s_addr), 3);
        send_word(32'h0000003F);
        repeat (2) @(negedge clk);
        #1;
        check("t3_nwr", 32'(wr_s), 4);
        check("t3_mode_after", 32'(s_mode), 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Boot sequencer for the instruction memory. It receives the program image byte-by-byte from the UART receiver and packs the bytes into 32-bit words. It writes each word into instruction memory over a single write port, then hands control to the core once the terminator word has been written. It drives the `mode` (STALL/LOAD/EXEC) seen by the fetch stage and holds the core in reset until the image is complete.

## Interface
Parameters:
- INST_SIZE, 10, instruction-memory address width in words (depth 2^INST_SIZE)
- TERM_WORD, 32'h0000003F, end-of-image marker word

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous, active-low reset
- start  in  1  single-cycle pulse: begin (re)load
- rx_valid  in  1  single-cycle strobe, rx_data valid
- rx_data  in  8  received byte
- imem_we  out  1  instruction-memory write enable
- imem_addr  out  INST_SIZE  word write address
- imem_wdata  out  32  word write data
- mode  out  2  0=STALL, 1=LOAD, 2=EXEC, 3=ERR
- cpu_rstn  out  1  active-low core reset; 1 only in EXEC
- done  out  1  image loaded (level, high in EXEC)
- err  out  1  overflow: memory full without terminator (level)
- word_count  out  INST_SIZE+1  words written in current load

## Operation
- All outputs are registered. Reset values: mode=0, cpu_rstn=0, done=0, err=0, imem_we=0, imem_addr=0, imem_wdata=0, word_count=0. The internal byte counter resets to 0.
- States: STALL, LOAD, EXEC, ERR. `mode` encodes the current state directly.
- STALL: wait for `start`. `rx_valid` is ignored.
- `start` in STALL, EXEC or ERR has the same effect:
  - next state is LOAD;
  - byte counter, word_count and write address are cleared;
  - cpu_rstn=0, done=0, err=0.
- `start` in LOAD is ignored.
- LOAD byte assembly:
  - Each `rx_valid` byte is shifted into the word assembler, little-endian: the 1st byte goes to [7:0], the 4th byte to [31:24].
  - The byte counter is 2 bits and wraps 3→0.
- On acceptance of the 4th byte, the assembled word is copied to imem_wdata and a one-cycle imem_we pulse is issued at the current write address.
  - The assembler is then free immediately, so back-to-back bytes need no stall.
- After each write, the write address and word_count increment.
- Terminator:
  - If the written word equals TERM_WORD, the terminator is itself written to memory.
  - On the edge that commits that write, state goes to EXEC: done=1, cpu_rstn=1.
- Overflow: if a non-terminator word is written at address 2^INST_SIZE-1, state goes to ERR on the committing edge, with err=1. The address does not wrap.
- EXEC and ERR: `rx_valid` is ignored and imem_we stays 0. A partially assembled word is discarded.
- A 1-3 byte partial word is never written.
- imem_addr holds its last value outside write cycles.

## Timing
- Byte → write: the 4th byte is accepted in cycle N. In cycle N+1, imem_we=1 with imem_addr/imem_wdata valid. In cycle N+2, imem_we=0.
- Terminator: if the word written in N+1 is TERM_WORD, then from N+2 onward mode=2, done=1, cpu_rstn=1.
- Overflow: if the word written in N+1 is at the last address and is not TERM_WORD, then from N+2 onward mode=3, err=1.
- `start` accepted in cycle S: mode=1 from S+1. cpu_rstn drops to 0 at S+1 if it was high.
- `rx_valid` coinciding with an accepted `start` is dropped.
- Bytes that arrive during an imem_we cycle are accepted normally. Minimum byte spacing is 1 cycle.
- Reset mid-load: on the next edge all outputs take their reset values. Words already written remain in memory.

## Test plan
- Reset, then start, then bytes 13 00 00 00 3F 00 00 00 at 1-cycle spacing.
  - Required: writes addr0=0x00000013 and addr1=0x0000003F, each a one-cycle we.
  - Required: mode=2, done=1, cpu_rstn=1 two cycles after the last byte; word_count=2.
- Bytes 78 56 34 12 spaced 434 cycles apart.
  - Required: a single write of imem_wdata=0x12345678 at addr0, exactly one cycle after the 4th byte.
- INST_SIZE=2, with four non-terminator words sent.
  - Required: writes at addr0..3, then mode=3, err=1, cpu_rstn=0.
  - Required: further bytes cause no imem_we.
- In EXEC, pulse start, then load 3F 00 00 00.
  - Required: cpu_rstn=0 and mode=1 the cycle after start.
  - Required: write at addr0, then EXEC again with word_count=1.
- Deassert rstn after 2 bytes of a word, release, start, then send 3F 00 00 00.
  - Required: the first write is at addr0 with 0x0000003F; no stale bytes appear in the word.
- rx_valid while in STALL, and rx_valid in the same cycle as start.
  - Required: both bytes ignored; the byte counter stays 0.
